// File: rtl/wb_row_sender.sv
// Writeback stage: drives the register-file write port and queues board-row and shape-commit
// events in a small FIFO that drains to the board engine over a valid/ready handshake.
module wb_row_sender #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IDX_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] PC_plus_8_in,
    input  logic [IDX_W-1:0]  writeregsel_in,
    input  logic              regWrite_in,
    input  logic              isJAL_in,
    input  logic              ifSendRow_in,
    input  logic              isMoveOrWriteShape_in,
    input  logic [IDX_W-1:0]  index_data_in,
    input  logic [DATA_W-1:0] row_data_in,
    input  logic [DATA_W-1:0] line_status_in,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic              ev_is_row,
    output logic              ev_is_commit,
    output logic [IDX_W-1:0]  ev_index,
    output logic [DATA_W-1:0] ev_row,
    output logic [DATA_W-1:0] line_status_q
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              is_row_mem    [FIFO_DEPTH];
    logic              is_commit_mem [FIFO_DEPTH];
    logic [IDX_W-1:0]  index_mem     [FIFO_DEPTH];
    logic [DATA_W-1:0] row_mem       [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic req;
    logic push;
    logic pop;
    logic not_full;

    assign req      = ifSendRow_in | isMoveOrWriteShape_in;
    assign ev_valid = (count_q != '0);
    assign not_full = (count_q < CNT_W'(FIFO_DEPTH));
    assign pop      = ev_valid & ev_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push     = req & (not_full | pop);
    assign stall    = req & ~push;

    assign rf_wdata = isJAL_in ? PC_plus_8_in : data_in;
    assign rf_waddr = writeregsel_in;
    assign rf_we    = regWrite_in & ~stall & (writeregsel_in != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            line_status_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && isMoveOrWriteShape_in) begin
                line_status_q <= line_status_in;
            end
        end
    end

    // Storage is not reset; the outputs below are gated by ev_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            is_row_mem[wr_ptr_q]    <= ifSendRow_in;
            is_commit_mem[wr_ptr_q] <= isMoveOrWriteShape_in;
            index_mem[wr_ptr_q]     <= index_data_in;
            row_mem[wr_ptr_q]       <= row_data_in;
        end
    end

    always_comb begin
        ev_is_row    = 1'b0;
        ev_is_commit = 1'b0;
        ev_index     = '0;
        ev_row       = '0;
        if (ev_valid) begin
            ev_is_row    = is_row_mem[rd_ptr_q];
            ev_is_commit = is_commit_mem[rd_ptr_q];
            ev_index     = index_mem[rd_ptr_q];
            ev_row       = row_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_wb_row_sender.sv
// Self-checking bench for wb_row_sender: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the writeback and event FIFO behaviour.
module tb_wb_row_sender;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] pc8_in = '0;
    logic [IW-1:0] wsel_in = '0;
    logic          regwrite_in = 1'b0;
    logic          isjal_in = 1'b0;
    logic          sendrow_in = 1'b0;
    logic          commit_in = 1'b0;
    logic [IW-1:0] index_in = '0;
    logic [DW-1:0] row_in = '0;
    logic [DW-1:0] ls_in = '0;
    logic          ev_ready = 1'b0;

    logic          rf_we;
    logic [IW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall;
    logic          ev_valid;
    logic          ev_is_row;
    logic          ev_is_commit;
    logic [IW-1:0] ev_index;
    logic [DW-1:0] ev_row;
    logic [DW-1:0] line_status_q;

    wb_row_sender #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_in               (data_in),
        .PC_plus_8_in          (pc8_in),
        .writeregsel_in        (wsel_in),
        .regWrite_in           (regwrite_in),
        .isJAL_in              (isjal_in),
        .ifSendRow_in          (sendrow_in),
        .isMoveOrWriteShape_in (commit_in),
        .index_data_in         (index_in),
        .row_data_in           (row_in),
        .line_status_in        (ls_in),
        .rf_we                 (rf_we),
        .rf_waddr              (rf_waddr),
        .rf_wdata              (rf_wdata),
        .stall                 (stall),
        .ev_valid              (ev_valid),
        .ev_ready              (ev_ready),
        .ev_is_row             (ev_is_row),
        .ev_is_commit          (ev_is_commit),
        .ev_index              (ev_index),
        .ev_row                (ev_row),
        .line_status_q         (line_status_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_row;
        logic          is_commit;
        logic [IW-1:0] idx;
        logic [DW-1:0] row;
    } ev_t;

    ev_t           model_q[$];
    logic [DW-1:0] model_ls = '0;
    logic          last_stall = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        regwrite_in = 1'b0;
        isjal_in    = 1'b0;
        sendrow_in  = 1'b0;
        commit_in   = 1'b0;
        wsel_in     = '0;
        data_in     = '0;
        pc8_in      = '0;
        index_in    = '0;
        row_in      = '0;
        ls_in       = '0;
        ev_ready    = 1'b0;
    endtask

    // One clock: check all outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit  req, pop, push, exp_stall, exp_valid;
        ev_t head;
        @(negedge clk);
        exp_valid = (model_q.size() != 0);
        head      = exp_valid ? model_q[0] : '0;
        req       = sendrow_in | commit_in;
        pop       = exp_valid & ev_ready;
        push      = req & ((model_q.size() < DEPTH) | pop);
        exp_stall = req & !push;
        check_eq("stall", 64'(stall), 64'(exp_stall));
        check_eq("rf_we", 64'(rf_we), 64'(regwrite_in & !exp_stall & (wsel_in != 0)));
        check_eq("rf_waddr", 64'(rf_waddr), 64'(wsel_in));
        check_eq("rf_wdata", 64'(rf_wdata), 64'(isjal_in ? pc8_in : data_in));
        check_eq("ev_valid", 64'(ev_valid), 64'(exp_valid));
        check_eq("ev_is_row", 64'(ev_is_row), 64'(head.is_row));
        check_eq("ev_is_commit", 64'(ev_is_commit), 64'(head.is_commit));
        check_eq("ev_index", 64'(ev_index), 64'(head.idx));
        check_eq("ev_row", 64'(ev_row), 64'(head.row));
        check_eq("line_status_q", 64'(line_status_q), 64'(model_ls));
        last_stall = exp_stall;
        @(posedge clk);
        if (pop) void'(model_q.pop_front());
        if (push) begin
            model_q.push_back('{is_row: sendrow_in, is_commit: commit_in, idx: index_in,
                                row: row_in});
            if (commit_in) model_ls = ls_in;
        end
        #1;
    endtask

    task automatic send_row(input logic [IW-1:0] idx, input logic [DW-1:0] row);
        sendrow_in = 1'b1;
        index_in   = idx;
        row_in     = row;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #12;
        check_eq("reset ev_valid", 64'(ev_valid), 64'(0));
        check_eq("reset line_status", 64'(line_status_q), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain register writeback, then link value, then suppressed r0 write.
        regwrite_in = 1'b1; wsel_in = 5'd8; data_in = 32'h1234;
        step();
        isjal_in = 1'b1; pc8_in = 32'h40; wsel_in = 5'd31;
        step();
        wsel_in = 5'd0;
        step();
        clear_inputs();

        // Single row event held while not ready, then drained.
        send_row(5'd3, 32'h0FF0);
        step();
        clear_inputs();
        repeat (5) step();
        check_eq("row held", 64'(ev_row), 64'(32'h0FF0));
        ev_ready = 1'b1;
        step();
        clear_inputs();
        step();

        // Fill the queue, stall a fifth instruction, then release it with a same-cycle pop.
        for (int i = 0; i < 4; i++) begin
            send_row(IW'(i), 32'hA000 + DW'(i));
            step();
        end
        send_row(5'd4, 32'hA004);
        regwrite_in = 1'b1; wsel_in = 5'd9; data_in = 32'h55;
        #1;
        check_eq("full stall", 64'(stall), 64'(1));
        check_eq("full rf_we", 64'(rf_we), 64'(0));
        step();
        ev_ready = 1'b1;
        #1;
        check_eq("pop release stall", 64'(stall), 64'(0));
        step();
        clear_inputs();
        ev_ready = 1'b1;
        repeat (6) step();
        clear_inputs();

        // Row and commit together form one entry and update line status.
        sendrow_in = 1'b1; commit_in = 1'b1; index_in = 5'd7; row_in = 32'hBEEF; ls_in = 32'hA5;
        step();
        clear_inputs();
        check_eq("commit line_status", 64'(line_status_q), 64'(32'hA5));
        step();
        ev_ready = 1'b1;
        step();
        clear_inputs();

        // Reset in the middle of a handshake discards everything.
        for (int i = 0; i < 3; i++) begin
            send_row(IW'(10 + i), 32'hC0 + DW'(i));
            commit_in = (i == 1);
            ls_in = 32'h77;
            step();
        end
        clear_inputs();
        ev_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async reset ev_valid", 64'(ev_valid), 64'(0));
        check_eq("async reset line_status", 64'(line_status_q), 64'(0));
        check_eq("async reset ev_row", 64'(ev_row), 64'(0));
        model_q.delete();
        model_ls = '0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();

        // Randomized traffic; a stalled instruction is re-presented unchanged.
        for (int c = 0; c < 400; c++) begin
            if (!last_stall) begin
                regwrite_in = 1'($urandom_range(0, 1));
                isjal_in    = 1'($urandom_range(0, 1));
                wsel_in     = ($urandom_range(0, 7) == 0) ? '0 : IW'($urandom);
                data_in     = $urandom;
                pc8_in      = $urandom;
                sendrow_in  = ($urandom_range(0, 9) < 5);
                commit_in   = ($urandom_range(0, 9) < 2);
                index_in    = IW'($urandom);
                row_in      = $urandom;
                ls_in       = $urandom;
            end
            ev_ready = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 8));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
